add_int32_serial: RTL and testbench



---
 rtl/pim_serial_pkg.sv | 10 +
 rtl/adder_1bit.sv | 25 ++
 rtl/add_int32_serial.sv | 97 +++++++++
 tb/tb_add_int32_serial.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pim_serial_pkg.sv
// Shared encodings for the serial PIM benchmark blocks.
package pim_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

endpackage

// File: rtl/adder_1bit.sv
// One-bit full adder; IMPL_TYPE picks the gate-level style of the carry path.
module adder_1bit #(
    parameter int IMPL_TYPE = 0
) (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic p;
    assign p   = A ^ B;
    assign Sum = p ^ Cin;

    generate
        if (IMPL_TYPE == 1) begin : g_mux
            // Propagate selects incoming carry, otherwise the generate bit (A==B).
            assign Cout = p ? Cin : A;
        end else begin : g_aoi
            assign Cout = (A & B) | (Cin & p);
        end
    endgenerate

endmodule

// File: rtl/add_int32_serial.sv
// Digit-serial adder: A + B mod 2^WIDTH, DIGIT bits per clock LSB first,
// with valid/ready handshakes on both sides.
module add_int32_serial
    import pim_serial_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIGIT     = 1,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_cfg
            $error("add_int32_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    serial_state_t    state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;

    assign chain[0] = carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_digit
            adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
                .A   (a_sh[i]),
                .B   (b_sh[i]),
                .Cin (chain[i]),
                .Sum (dsum[i]),
                .Cout(chain[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)     next_state = RUN;
            RUN:     if (cnt == LAST)  next_state = DONE;
            DONE:    if (out_ready)    next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Sum fills from the MSB side so after N steps digit 0 lands at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            Sum   <= {dsum, Sum[WIDTH-1:DIGIT]};
            carry <= chain[DIGIT];
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) Cout <= chain[DIGIT];
        end
    end

endmodule

// File: tb/tb_add_int32_serial.sv
// Directed checks of the serial adder at DIGIT=1 plus a streamed DIGIT=4 run.
module tb_add_int32_serial;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
    logic        rst4, in_valid4, in_ready4, out_valid4, out_ready4, cout4;
    logic [31:0] a4, b4, sum4;

    add_int32_serial #(.WIDTH(32), .DIGIT(1), .IMPL_TYPE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum), .Cout(cout)
    );

    add_int32_serial #(.WIDTH(32), .DIGIT(4), .IMPL_TYPE(1)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .Sum(sum4), .Cout(cout4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after an edge; returns edges from accept to out_valid.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        check("issue_in_ready", in_ready, 1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [32:0] exp;
        logic [31:0] x, y;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        rst4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);

        // Small sum, exact latency
        issue(32'd5, 32'd3, lat);
        check("t1_latency", lat, 32);
        check("t1_sum", sum, 32'd8);
        check("t1_cout", cout, 0);
        take_result();

        // Wrap and signed-overflow boundaries
        issue(32'hFFFF_FFFF, 32'd1, lat);
        check("t2a_sum", sum, 32'h0000_0000);
        check("t2a_cout", cout, 1);
        take_result();
        issue(32'h7FFF_FFFF, 32'd1, lat);
        check("t2b_sum", sum, 32'h8000_0000);
        check("t2b_cout", cout, 0);

        // Hold in DONE while inputs wiggle
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; in_valid = ~in_valid;
            @(posedge clk); #1;
            check("t3_sum_hold", sum, 32'h8000_0000);
            check("t3_cout_hold", cout, 0);
            check("t3_in_ready", in_ready, 0);
            check("t3_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        take_result();
        check("t3_back_idle", in_ready, 1);

        // Reset part way through an operation
        a = 32'h1234_5678; b = 32'h1111_1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("t4_mid_out_valid", out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_rst_sum", sum, 0);
        check("t4_rst_cout", cout, 0);
        check("t4_rst_in_ready", in_ready, 1);
        check("t4_rst_out_valid", out_valid, 0);
        issue(32'h1234_5678, 32'h1111_1111, lat);
        check("t4_latency", lat, 32);
        check("t4_sum", sum, 32'h2345_6789);
        check("t4_cout", cout, 0);
        take_result();

        // MSB carry-out, then back-to-back accept
        issue(32'h8000_0000, 32'h8000_0000, lat);
        check("t6_sum", sum, 32'h0);
        check("t6_cout", cout, 1);
        check("t6_in_ready_done", in_ready, 0);
        a = 32'd2; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t6_hs_in_ready", in_ready, 1);
        check("t6_hs_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_accepted", in_ready, 0);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
        check("t6b_latency", lat, 32);
        check("t6b_sum", sum, 32'd5);
        check("t6b_cout", cout, 0);
        take_result();

        // DIGIT=4 stream, in_valid and out_ready held high
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            y = (i == 0) ? 32'h0000_0001 : $urandom;
            exp = {1'b0, x} + {1'b0, y};
            check("t5_in_ready", in_ready4, 1);
            a4 = x; b4 = y;
            @(posedge clk); #1;
            a4 = ~x; b4 = $urandom;
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!out_valid4 && lat < 50);
            check("t5_latency", lat, 8);
            check("t5_sum", sum4, exp[31:0]);
            check("t5_cout", cout4, exp[32]);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
